pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 6-stage core (PC, IF, ID, EX, MEM, WB).
//  Merges stage stall requests into the stall vector consumed by the PC register and the stage registers.
//  Sequences PC redirects: branch targets from ID and exception handler entry, the latter with a pipeline flush.
//  Holds a pending branch across stalls and tracks stall statistics.
// PARAMETERS
//  ADDR_W      32    width of PC / target addresses (equals `ADDR_WIDTH)
//  REFILL_CYC  2     cycles after a flush during which branch_i is ignored (wrong-path), >=1
//  TIMEOUT     1024  consecutive stall cycles that set stall_timeout_o, >=2
// PORTS
//  clk_i            in   1       core clock
//  rst_n_i          in   1       asynchronous active-low reset
//  stallreq_id_i    in   1       ID requests stall (load-use)
//  stallreq_ex_i    in   1       EX requests stall (multi-cycle op)
//  stallreq_mem_i   in   1       MEM requests stall (bus wait)
//  branch_i         in   1       ID resolved taken branch this cycle
//  branch_tgt_i     in   ADDR_W  branch target
//  excp_i           in   1       exception raised by MEM this cycle
//  excp_tgt_i       in   ADDR_W  handler address
//  stall_o          out  6       per-stage hold, bit0=PC ... bit5=WB, 1=`STOP
//  flush_o          out  1       one-cycle clear of IF..MEM registers
//  pc_load_o        out  1       one-cycle: PC register loads new_pc_o
//  new_pc_o         out  ADDR_W  redirect address, valid while pc_load_o=1
//  stall_cnt_o      out  32      total stalled cycles, saturating
//  stall_timeout_o  out  1       sticky: a stall lasted TIMEOUT cycles
// BEHAVIOUR
//  Reset (async assert, sync release): state=RUN, flush_o=0, pc_load_o=0, new_pc_o=0, pend_vld=0,
//   stall_cnt_o=0, stall_timeout_o=0, refill counter=0; stall_o=0 while rst_n_i=0.
//  stall_o is combinational, same cycle as the request; priority: mem->6'b011111, ex->6'b001111,
//   id->6'b000111, none->6'b000000. Forced to 0 in FLUSH.
//  flush_o, pc_load_o, new_pc_o are registered: a redirect appears one cycle after its cause.
//  FSM states: RUN, STALL, FLUSH, REFILL.
//  RUN: excp_i -> FLUSH, latch excp_tgt_i. Else any stallreq -> STALL; a branch_i in the same cycle
//   is latched in pend (pend_vld=1, pend_tgt). Else branch_i -> next cycle pc_load_o=1, new_pc_o=tgt.
//  STALL: excp_i -> FLUSH (pend_vld cleared). branch_i -> latch pend (later overwrites earlier).
//   All requests low -> RUN; if pend_vld: next cycle pc_load_o=1, new_pc_o=pend_tgt, pend_vld=0.
//  FLUSH (1 cycle): outputs flush_o=1, pc_load_o=1, new_pc_o=latched handler; stall_o=0;
//   excp_i ignored; -> REFILL with counter=REFILL_CYC.
//  REFILL: branch_i ignored; stall_o per requests; counter decrements to 0 then -> RUN;
//   excp_i -> FLUSH.
//  Simultaneous excp_i and branch_i: exception wins, branch dropped.
//  Simultaneous excp_i and stallreq: exception wins; stall_o still follows the requests in the
//   detect cycle.
//  stall_cnt_o: +1 each cycle stall_o!=0, holds at 32'hFFFFFFFF.
//  Timeout: consecutive-stall counter resets to 0 on any cycle with stall_o==0 and saturates at
//   TIMEOUT; when it reaches TIMEOUT, stall_timeout_o=1 (sticky until reset).
//  Reset mid-operation: everything returns to reset values immediately; pending branch lost.
// STRUCTURE
//  defines.v: `STOP/`NOSTOP, `ADDR_WIDTH, STALL_ID/EX/MEM 6-bit vectors, FSM state encodings (2-bit).
//  Sub-module stall_mon: saturating stall_cnt_o, consecutive counter, sticky timeout flag.
//  FSM, pend register and stall encoder stay in pipe_ctrl.
// TESTING
//  Reset, no requests, 10 cycles -> stall_o=0, pc_load_o=0, stall_cnt_o=0.
//  stallreq_mem_i high 3 cycles, stallreq_id_i high concurrently -> stall_o=6'b011111 those
//   cycles, stall_cnt_o=3.
//  branch_i tgt=32'h100 in RUN -> next cycle pc_load_o=1, new_pc_o=32'h100, one cycle only.
//  branch_i tgt=32'h200 during 4-cycle ex stall -> no load during stall; load 32'h200 the cycle
//   after the stall drops.
//  excp_i tgt=32'h80 with branch_i in the same cycle -> next cycle flush_o=1, pc_load_o=1,
//   new_pc_o=32'h80; a branch_i within REFILL_CYC cycles produces no load.
//  stallreq_mem_i held TIMEOUT cycles (TIMEOUT=8) -> stall_timeout_o=1 and stays 1 after release;
//   rst_n_i pulse mid-stall clears all.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall vectors and FSM state type for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit 0 is the PC register, bit 5 is WB; a stalled stage also holds everything upstream of it.
  localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
  localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP, STOP, STOP, STOP, STOP};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    REFILL = 2'd3
  } state_t;

  function automatic logic [5:0] encode_stall(input logic id, input logic ex, input logic mem);
    logic [5:0] vec;
    vec = STALL_NONE;
    if (mem)     vec = STALL_MEM;
    else if (ex) vec = STALL_EX;
    else if (id) vec = STALL_ID;
    return vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-facing signals of the pipeline controller: stall requests, redirect causes and the resulting controls.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_WIDTH
);

  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              stallreq_mem_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_tgt_i;
  logic              excp_i;
  logic [ADDR_W-1:0] excp_tgt_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              pc_load_o;
  logic [ADDR_W-1:0] new_pc_o;

  modport master (
    output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output branch_i, branch_tgt_i, excp_i, excp_tgt_i,
    input  stall_o, flush_o, pc_load_o, new_pc_o
  );

  modport slave (
    input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  branch_i, branch_tgt_i, excp_i, excp_tgt_i,
    output stall_o, flush_o, pc_load_o, new_pc_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_mon.sv
// Stall statistics: saturating total of stalled cycles and a sticky flag for an over-long continuous stall.
module pipe_ctrl_stall_mon #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  output logic [31:0] stall_cnt_o,
  output logic        stall_timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CONSEC_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CONSEC_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] consec_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  // The run length saturates so a very long stall cannot wrap around and look short again.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      consec_q <= '0;
    end else if (!stall_i) begin
      consec_q <= '0;
    end else if (consec_q != CONSEC_MAX) begin
      consec_q <= consec_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_timeout_o <= 1'b0;
    end else if (stall_i && (consec_q == CONSEC_LAST)) begin
      stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests and sequences branch and exception PC redirects.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int REFILL_CYC = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  pipe_ctrl_if.slave  pif,
  output logic [31:0] stall_cnt_o,
  output logic        stall_timeout_o
);

  localparam int RCW = $clog2(REFILL_CYC + 1);
  localparam logic [RCW-1:0] REFILL_LOAD = RCW'(REFILL_CYC);

  state_t            state_q, state_nxt;
  logic              flush_q, flush_nxt;
  logic              load_q, load_nxt;
  logic [ADDR_W-1:0] new_pc_q, new_pc_nxt;
  logic              pend_vld_q, pend_vld_nxt;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_nxt;
  logic [RCW-1:0]    refill_q, refill_nxt;
  logic              any_req;
  logic [5:0]        stall_vec;

  assign any_req = pif.stallreq_id_i | pif.stallreq_ex_i | pif.stallreq_mem_i;

  // The flush cycle clears the stage registers, so holding any of them would defeat it.
  always_comb begin
    stall_vec = encode_stall(pif.stallreq_id_i, pif.stallreq_ex_i, pif.stallreq_mem_i);
    if (!rst_n_i || (state_q == FLUSH)) begin
      stall_vec = STALL_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      flush_q    <= 1'b0;
      load_q     <= 1'b0;
      new_pc_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      refill_q   <= '0;
    end else begin
      state_q    <= state_nxt;
      flush_q    <= flush_nxt;
      load_q     <= load_nxt;
      new_pc_q   <= new_pc_nxt;
      pend_vld_q <= pend_vld_nxt;
      pend_tgt_q <= pend_tgt_nxt;
      refill_q   <= refill_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    flush_nxt    = 1'b0;
    load_nxt     = 1'b0;
    new_pc_nxt   = new_pc_q;
    pend_vld_nxt = pend_vld_q;
    pend_tgt_nxt = pend_tgt_q;
    refill_nxt   = refill_q;

    unique case (state_q)
      RUN: begin
        if (pif.excp_i) begin
          state_nxt  = FLUSH;
          flush_nxt  = 1'b1;
          load_nxt   = 1'b1;
          new_pc_nxt = pif.excp_tgt_i;
        end else if (any_req) begin
          state_nxt = STALL;
          if (pif.branch_i) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = pif.branch_tgt_i;
          end
        end else if (pif.branch_i) begin
          load_nxt   = 1'b1;
          new_pc_nxt = pif.branch_tgt_i;
        end
      end

      STALL: begin
        if (pif.excp_i) begin
          state_nxt    = FLUSH;
          flush_nxt    = 1'b1;
          load_nxt     = 1'b1;
          new_pc_nxt   = pif.excp_tgt_i;
          pend_vld_nxt = 1'b0;
        end else if (any_req) begin
          if (pif.branch_i) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = pif.branch_tgt_i;
          end
        end else begin
          // A branch resolving in the release cycle is newer than anything parked in pend.
          state_nxt    = RUN;
          pend_vld_nxt = 1'b0;
          if (pif.branch_i) begin
            load_nxt   = 1'b1;
            new_pc_nxt = pif.branch_tgt_i;
          end else if (pend_vld_q) begin
            load_nxt   = 1'b1;
            new_pc_nxt = pend_tgt_q;
          end
        end
      end

      FLUSH: begin
        state_nxt  = REFILL;
        refill_nxt = REFILL_LOAD;
      end

      REFILL: begin
        if (pif.excp_i) begin
          state_nxt  = FLUSH;
          flush_nxt  = 1'b1;
          load_nxt   = 1'b1;
          new_pc_nxt = pif.excp_tgt_i;
        end else if (refill_q <= RCW'(1)) begin
          state_nxt  = RUN;
          refill_nxt = '0;
        end else begin
          refill_nxt = refill_q - RCW'(1);
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign pif.stall_o   = stall_vec;
  assign pif.flush_o   = flush_q;
  assign pif.pc_load_o = load_q;
  assign pif.new_pc_o  = new_pc_q;

  pipe_ctrl_stall_mon #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_mon (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .stall_i         (|stall_vec),
    .stall_cnt_o     (stall_cnt_o),
    .stall_timeout_o (stall_timeout_o)
  );

endmodule
